stream_out_fifo_pio: RTL and testbench

Parametrised successor to the Nios II output-port slave. It is an Avalon-MM register slave driving a WIDTH-bit output. The output runs in one of two modes:
- **Direct:** the classic immediate-update PIO behaviour.
- **Stream:** CPU writes are queued in a DEPTH-entry FIFO and drained through a valid/ready handshake, paced by a programmable divider.

It sits between the Nios II data master and downstream fabric logic. It raises an interrupt on low FIFO level or on overflow.

---
 rtl/stream_out_fifo_pio.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_stream_out_fifo_pio.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_out_fifo_pio.sv
// -----------------------------------------------------------------------------
// stream_out_fifo_pio
//
// Avalon-MM register slave that drives a WIDTH-bit output port. It has two
// output modes:
//   direct : a DATA write updates out_data immediately and pulses out_valid
//            for one cycle.
//   stream : DATA writes are queued in a DEPTH-entry FIFO and drained into
//            out_data through a valid/ready handshake. Successive loads are
//            spaced by at least DIVIDER+1 cycles.
// A registered, level-sensitive irq reports a low FIFO level (stream mode)
// and/or a sticky overflow.
//
// Register map (address):
//   0 DATA      W: direct update / FIFO push      R: out_data
//   1 STATUS    R: [8:0] level, [16] empty, [17] full, [18] overflow,
//                  [19] out_valid                 W: bit 18 clears overflow
//   2 CONTROL   R/W: [0] enable, [1] mode, [2] irq_low_en, [3] irq_ovf_en,
//                    [4] flush (write-only, reads 0)
//   3 DIVIDER   R/W: [DIV_W-1:0] pacing divider
//   4 THRESHOLD R/W: [8:0] low-level watermark
//
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata  Avalon-MM slave write side (no wait states)
//   readdata            combinational read data, zero-extended
//   out_data, out_valid registered output word and its valid flag
//   out_ready           downstream accept
//   irq                 registered level interrupt
// -----------------------------------------------------------------------------
module stream_out_fifo_pio #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_DIV    = 3'd3;
  localparam logic [2:0] REG_THR    = 3'd4;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             enable_reg,     enable_next;
  logic             mode_reg,       mode_next;
  logic             irq_low_en_reg, irq_low_en_next;
  logic             irq_ovf_en_reg, irq_ovf_en_next;
  logic [DIV_W-1:0] divider_reg,    divider_next;
  logic [8:0]       threshold_reg,  threshold_next;
  logic             overflow_reg,   overflow_next;
  logic [AW-1:0]    wr_ptr_reg,     wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg,     rd_ptr_next;
  logic [LW-1:0]    level_reg,      level_next;
  logic [DIV_W-1:0] pace_cnt_reg,   pace_cnt_next;
  logic [WIDTH-1:0] out_data_reg,   out_data_next;
  logic             out_valid_reg,  out_valid_next;
  logic             irq_reg,        irq_next;

  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Decode and FIFO control terms
  // ---------------------------------------------------------------------------
  logic             wr_en;
  logic             wr_data;
  logic             wr_status;
  logic             wr_ctrl;
  logic             wr_div;
  logic             wr_thr;
  logic             flush;
  logic             empty;
  logic             full;
  logic             push;
  logic             push_ok;
  logic             load;
  logic [WIDTH-1:0] head;

  // Gathers the write-data bits that no register field consumes.
  logic             unused_bits;

  assign wr_en     = chipselect && !write_n;
  assign wr_data   = wr_en && (address == REG_DATA);
  assign wr_status = wr_en && (address == REG_STATUS);
  assign wr_ctrl   = wr_en && (address == REG_CTRL);
  assign wr_div    = wr_en && (address == REG_DIV);
  assign wr_thr    = wr_en && (address == REG_THR);

  // An explicit flush bit or any mode switch discards the queue and the
  // pending output word.
  assign flush   = wr_ctrl && (writedata[4] || (writedata[1] != mode_reg));

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LW'(DEPTH));
  assign push    = wr_data && mode_reg;
  // A push into a full FIFO is dropped even if a pop frees a slot this edge.
  assign push_ok = push && !full;

  // The load rule only looks at registered level, so a word pushed into an
  // empty FIFO becomes loadable one edge later (no fall-through).
  assign load = mode_reg && enable_reg && !empty && (pace_cnt_reg == '0) &&
                (!out_valid_reg || out_ready) && !flush;

  assign head = mem[rd_ptr_reg];

  assign unused_bits = ^writedata;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    enable_next     = enable_reg;
    mode_next       = mode_reg;
    irq_low_en_next = irq_low_en_reg;
    irq_ovf_en_next = irq_ovf_en_reg;
    divider_next    = divider_reg;
    threshold_next  = threshold_reg;
    overflow_next   = overflow_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    level_next      = level_reg;
    pace_cnt_next   = pace_cnt_reg;
    out_data_next   = out_data_reg;
    out_valid_next  = out_valid_reg;

    // Register file
    if (wr_ctrl) begin
      enable_next     = writedata[0];
      mode_next       = writedata[1];
      irq_low_en_next = writedata[2];
      irq_ovf_en_next = writedata[3];
    end
    if (wr_div) begin
      divider_next = writedata[DIV_W-1:0];
    end
    if (wr_thr) begin
      threshold_next = writedata[8:0];
    end

    // Sticky overflow; setting wins over a clear (they cannot coincide anyway
    // since they need different addresses).
    if (push && full) begin
      overflow_next = 1'b1;
    end else if (wr_status && writedata[18]) begin
      overflow_next = 1'b0;
    end

    // FIFO pointers and level
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (load) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      if (push_ok && !load) begin
        level_next = level_reg + LW'(1);
      end else if (!push_ok && load) begin
        level_next = level_reg - LW'(1);
      end
    end

    // Pacing counter runs down regardless of enable.
    if (flush) begin
      pace_cnt_next = '0;
    end else if (load) begin
      pace_cnt_next = divider_reg;
    end else if (pace_cnt_reg != '0) begin
      pace_cnt_next = pace_cnt_reg - DIV_W'(1);
    end

    // Output word
    if (!mode_reg) begin
      // Direct mode: valid is a one-cycle strobe per DATA write and ignores
      // out_ready. A CONTROL write (flush) is never a DATA write, so the
      // strobe is low in that case as well.
      out_valid_next = wr_data;
      if (wr_data) begin
        out_data_next = writedata[WIDTH-1:0];
      end
    end else if (flush) begin
      out_valid_next = 1'b0;
    end else if (load) begin
      out_data_next  = head;
      out_valid_next = 1'b1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    irq_next = (irq_low_en_reg && mode_reg && enable_reg &&
                (9'(level_reg) <= threshold_reg)) ||
               (irq_ovf_en_reg && overflow_reg);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_reg     <= 1'b0;
      mode_reg       <= 1'b0;
      irq_low_en_reg <= 1'b0;
      irq_ovf_en_reg <= 1'b0;
      divider_reg    <= '0;
      threshold_reg  <= '0;
      overflow_reg   <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      pace_cnt_reg   <= '0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      irq_reg        <= 1'b0;
    end else begin
      enable_reg     <= enable_next;
      mode_reg       <= mode_next;
      irq_low_en_reg <= irq_low_en_next;
      irq_ovf_en_reg <= irq_ovf_en_next;
      divider_reg    <= divider_next;
      threshold_reg  <= threshold_next;
      overflow_reg   <= overflow_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      level_reg      <= level_next;
      pace_cnt_reg   <= pace_cnt_next;
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      irq_reg        <= irq_next;
    end
  end

  // FIFO storage has no reset: after reset or flush the pointers mark every
  // entry as free, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= writedata[WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (combinational, zero-extended)
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA: begin
        readdata = 32'(out_data_reg);
      end
      REG_STATUS: begin
        readdata[8:0] = 9'(level_reg);
        readdata[16]  = empty;
        readdata[17]  = full;
        readdata[18]  = overflow_reg;
        readdata[19]  = out_valid_reg;
      end
      REG_CTRL: begin
        readdata[3:0] = {irq_ovf_en_reg, irq_low_en_reg, mode_reg, enable_reg};
      end
      REG_DIV: begin
        readdata = 32'(divider_reg);
      end
      REG_THR: begin
        readdata[8:0] = threshold_reg;
      end
      default: begin
        readdata = '0;
      end
    endcase
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign irq       = irq_reg;

endmodule

// File: tb/tb_stream_out_fifo_pio.sv
// -----------------------------------------------------------------------------
// tb_stream_out_fifo_pio
//
// Self-checking bench for stream_out_fifo_pio (WIDTH=8, DEPTH=16, DIV_W=16).
// Inputs change 2 ns after each rising edge; outputs are sampled mid-cycle.
// A monitor on the falling edge records every word that newly appears on the
// output (a load) together with its cycle number, and counts any change of
// out_data while a word is stalled by out_ready=0.
// -----------------------------------------------------------------------------
module tb_stream_out_fifo_pio;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             irq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] loads[$];
  int               load_cyc[$];
  int               stab_viol = 0;
  logic             prev_valid = 1'b0;
  logic             prev_ready = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;

  stream_out_fifo_pio #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .DIV_W(DIV_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Load / stability monitor
  always @(negedge clk) begin
    if (out_valid && (!prev_valid || prev_ready)) begin
      loads.push_back(out_data);
      load_cyc.push_back(cyc);
    end
    if (out_valid && prev_valid && !prev_ready && (out_data !== prev_data)) begin
      stab_viol++;
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Bus helpers (stimulus only)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #2;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic clear_mon();
    loads.delete();
    load_cyc.delete();
    stab_viol = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] e;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b data=%0h irq=%0b, expected 0 0 0",
               out_valid, out_data, irq);
    end
    reset_n = 1'b1;
    step();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      e = (a == 1) ? 32'h0001_0000 : 32'h0;
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL reset_readback addr %0d: got %08h, expected %08h", a, d, e);
      end
    end
  endtask

  task automatic test_direct();
    logic [31:0]      d;
    logic [31:0]      v;
    logic [WIDTH-1:0] e;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 32'h0000_00A5 : $urandom;
      e = v[WIDTH-1:0];
      out_ready = 1'($urandom_range(0, 1));
      wr(3'd0, v);
      checks++;
      if (out_data !== e || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL direct_write %0d: data=%0h valid=%0b, expected %0h 1",
                 i, out_data, out_valid, e);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== e) begin
        errors++;
        $display("FAIL direct_pulse %0d: data=%0h valid=%0b, expected %0h 0",
                 i, out_data, out_valid, e);
      end
      rd(3'd0, d);
      checks++;
      if (d !== 32'(e)) begin
        errors++;
        $display("FAIL direct_readback %0d: got %08h, expected %08h", i, d, 32'(e));
      end
      rd(3'd1, d);
      checks++;
      if (d !== 32'h0001_0000) begin
        errors++;
        $display("FAIL direct_status %0d: got %08h, expected 00010000", i, d);
      end
    end
  endtask

  task automatic test_stream_throughput();
    logic [WIDTH-1:0] exp_q[$];
    logic [31:0]      v;
    int               cyc_e;
    out_ready = 1'b1;
    wr(3'd2, 32'h3);
    wr(3'd3, 32'h0);
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      exp_q.push_back(v[WIDTH-1:0]);
      wr(3'd0, v);
      if (i == 0) cyc_e = cyc;
    end
    repeat (4) step();
    checks++;
    if (loads.size() != 3) begin
      errors++;
      $display("FAIL throughput_count: got %0d loads, expected 3", loads.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (loads[i] !== exp_q[i] || load_cyc[i] != cyc_e + 1 + i) begin
          errors++;
          $display("FAIL throughput_word %0d: data=%0h at cycle %0d, expected %0h at cycle %0d",
                   i, loads[i], load_cyc[i], exp_q[i], cyc_e + 1 + i);
        end
      end
    end
  endtask

  task automatic test_pacing();
    logic [WIDTH-1:0] exp_q[$];
    logic [31:0]      v;
    int               n;
    wr(3'd3, 32'd3);
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      v = $urandom;
      exp_q.push_back(v[WIDTH-1:0]);
      wr(3'd0, v);
    end
    n = 0;
    while (loads.size() < 4 && n < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    out_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (loads.size() != 4) begin
      errors++;
      $display("FAIL pacing_count: got %0d loads, expected 4", loads.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (loads[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL pacing_word %0d: got %0h, expected %0h", i, loads[i], exp_q[i]);
        end
        if (i > 0) begin
          checks++;
          if (load_cyc[i] - load_cyc[i-1] < 4) begin
            errors++;
            $display("FAIL pacing_gap %0d: got %0d cycles, expected >= 4",
                     i, load_cyc[i] - load_cyc[i-1]);
          end
        end
      end
    end
    checks++;
    if (stab_viol != 0) begin
      errors++;
      $display("FAIL pacing_stable: %0d data changes while stalled, expected 0", stab_viol);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pacing_drained: valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w[$];
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] v;
    int          n;
    int          lvl;
    wr(3'd3, 32'd0);
    wr(3'd2, 32'h2);
    for (int i = 0; i < 17; i++) begin
      v = $urandom;
      w.push_back(v);
      wr(3'd0, v);
    end
    lvl = (17 > DEPTH) ? DEPTH : 17;
    e = 32'(lvl) | ((lvl == DEPTH) ? 32'h0002_0000 : 32'h0) |
        ((17 > DEPTH) ? 32'h0004_0000 : 32'h0);
    rd(3'd1, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL overflow_status: got %08h, expected %08h", d, e);
    end
    clear_mon();
    out_ready = 1'b1;
    wr(3'd2, 32'h3);
    n = 0;
    while (loads.size() < lvl && n < 100) begin
      step();
      n++;
    end
    repeat (5) step();
    checks++;
    if (loads.size() != lvl) begin
      errors++;
      $display("FAIL overflow_drain_count: got %0d words, expected %0d", loads.size(), lvl);
    end else begin
      for (int i = 0; i < lvl; i++) begin
        v = w[i];
        checks++;
        if (loads[i] !== v[WIDTH-1:0]) begin
          errors++;
          $display("FAIL overflow_word %0d: got %0h, expected %0h", i, loads[i], v[WIDTH-1:0]);
        end
      end
    end
    rd(3'd1, d);
    checks++;
    if (d !== 32'h0005_0000) begin
      errors++;
      $display("FAIL overflow_sticky: got %08h, expected 00050000", d);
    end
    wr(3'd1, 32'h0004_0000);
    rd(3'd1, d);
    checks++;
    if (d !== 32'h0001_0000) begin
      errors++;
      $display("FAIL overflow_clear: got %08h, expected 00010000", d);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int          nl;
    int          lvl_prev;
    int          lvl_now;
    logic        e_irq;
    wr(3'd3, 32'd3);
    wr(3'd4, 32'd2);
    wr(3'd2, 32'h6);
    rd(3'd4, d);
    checks++;
    if (d !== 32'd2) begin
      errors++;
      $display("FAIL irq_threshold_rb: got %08h, expected 00000002", d);
    end
    rd(3'd3, d);
    checks++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL irq_divider_rb: got %08h, expected 00000003", d);
    end
    for (int i = 0; i < 5; i++) wr(3'd0, $urandom);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_disabled: got %0b, expected 0", irq);
    end
    out_ready = 1'b1;
    wr(3'd2, 32'h7);
    address  = 3'd1;
    lvl_prev = 5;
    for (int t = 1; t <= 24; t++) begin
      step();
      // Loads at 1, 5, 9, ... edges after enabling, five words in total.
      nl = (t - 1) / 4 + 1;
      if (nl > 5) nl = 5;
      lvl_now = 5 - nl;
      e_irq   = (lvl_prev <= 2);
      #1;
      checks++;
      if (readdata[8:0] !== 9'(lvl_now) || irq !== e_irq) begin
        errors++;
        $display("FAIL irq_low t=%0d: level=%0d irq=%0b, expected level=%0d irq=%0b",
                 t, readdata[8:0], irq, lvl_now, e_irq);
      end
      lvl_prev = lvl_now;
    end
    // Overflow interrupt
    wr(3'd2, 32'hA);
    for (int i = 0; i < DEPTH; i++) wr(3'd0, $urandom);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_ovf_before: got %0b, expected 0", irq);
    end
    wr(3'd0, $urandom);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_ovf_same_edge: got %0b, expected 0", irq);
    end
    step();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_ovf_rise: got %0b, expected 1", irq);
    end
    repeat (3) step();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_ovf_hold: got %0b, expected 1", irq);
    end
    wr(3'd1, 32'h0004_0000);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_ovf_clear_edge: got %0b, expected 1", irq);
    end
    step();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_ovf_cleared: got %0b, expected 0", irq);
    end
  endtask

  task automatic test_flush();
    logic [31:0]      d;
    logic [31:0]      v;
    logic [WIDTH-1:0] w0;
    wr(3'd3, 32'd0);
    wr(3'd2, 32'h12);
    rd(3'd1, d);
    checks++;
    if (d !== 32'h0001_0000) begin
      errors++;
      $display("FAIL flush_full: got %08h, expected 00010000", d);
    end
    out_ready = 1'b0;
    wr(3'd2, 32'h3);
    w0 = '0;
    for (int i = 0; i < 9; i++) begin
      v = $urandom;
      if (i == 0) w0 = v[WIDTH-1:0];
      wr(3'd0, v);
    end
    rd(3'd1, d);
    checks++;
    if (d !== 32'h0008_0008 || out_data !== w0) begin
      errors++;
      $display("FAIL flush_prefill: status=%08h data=%0h, expected 00080008 %0h", d, out_data, w0);
    end
    wr(3'd2, 32'h13);
    rd(3'd1, d);
    checks++;
    if (d !== 32'h0001_0000 || out_valid !== 1'b0 || out_data !== w0) begin
      errors++;
      $display("FAIL flush_mid: status=%08h valid=%0b data=%0h, expected 00010000 0 %0h",
               d, out_valid, out_data, w0);
    end
    rd(3'd2, d);
    checks++;
    if (d !== 32'h3) begin
      errors++;
      $display("FAIL flush_ctrl_rb: got %08h, expected 00000003", d);
    end
    repeat (2) step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: valid=%0b, expected 0", out_valid);
    end
    wr(3'd2, 32'h2);
    for (int i = 0; i < 3; i++) wr(3'd0, $urandom);
    rd(3'd1, d);
    checks++;
    if (d !== 32'h0000_0003) begin
      errors++;
      $display("FAIL mode_prefill: got %08h, expected 00000003", d);
    end
    wr(3'd2, 32'h0);
    rd(3'd1, d);
    checks++;
    if (d !== 32'h0001_0000) begin
      errors++;
      $display("FAIL mode_change_flush: got %08h, expected 00010000", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] e;
    int          lvl;
    int          n;
    n = 20;
    out_ready = 1'b0;
    wr(3'd2, 32'hB);
    for (int i = 0; i < n; i++) wr(3'd0, $urandom);
    step();
    // One word sits in out_data; the rest fill the queue up to DEPTH.
    lvl = (n - 1 > DEPTH) ? DEPTH : n - 1;
    e = 32'(lvl) | 32'h0008_0000 | ((lvl == DEPTH) ? 32'h0002_0000 : 32'h0) |
        ((n - 1 > DEPTH) ? 32'h0004_0000 : 32'h0);
    rd(3'd1, d);
    checks++;
    if (d !== e || irq !== 1'b1) begin
      errors++;
      $display("FAIL resetmid_pre: status=%08h irq=%0b, expected %08h 1", d, irq, e);
    end
    out_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || irq !== 1'b0 || readdata !== 32'h0001_0000) begin
      errors++;
      $display("FAIL resetmid_async: valid=%0b data=%0h irq=%0b status=%08h, expected 0 0 0 00010000",
               out_valid, out_data, irq, readdata);
    end
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    rd(3'd2, d);
    checks++;
    if (d !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL resetmid_after: ctrl=%08h valid=%0b, expected 00000000 0", d, out_valid);
    end
  endtask

  initial begin
    reset_n    = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    out_ready  = 1'b0;
    test_reset();
    test_direct();
    test_stream_throughput();
    test_pacing();
    test_overflow();
    test_irq();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
